// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order FIFO of tournament-predictor decisions, resolved at the head to train the tables.
// A mispredict flushes every younger entry and drops a same-cycle enqueue as wrong-path.
module branch_resolve_queue #(
  parameter int bht_idx_width_p = 10,
  parameter int ghist_width_p   = 12,
  parameter int depth_p         = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       pred_v_i,
  output logic                       pred_ready_o,
  input  logic [bht_idx_width_p-1:0] pred_idx_i,
  input  logic [ghist_width_p-1:0]   pred_ghist_i,
  input  logic                       pred_taken_i,
  input  logic                       pred_local_i,
  input  logic                       pred_global_i,
  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic [ghist_width_p-1:0]   ghist_w_o,
  output logic                       taken_o,
  output logic                       correct_o,
  output logic                       choice_v_o,
  output logic                       choice_global_o,
  output logic                       mispredict_o,
  output logic [$clog2(depth_p):0]   count_o,
  output logic                       err_o
);
  localparam int pw = $clog2(depth_p);
  logic [bht_idx_width_p-1:0] idx_q    [depth_p];
  logic [ghist_width_p-1:0]   ghist_q  [depth_p];
  logic                       taken_q  [depth_p];
  logic                       local_q  [depth_p];
  logic                       global_q [depth_p];
  logic [pw-1:0] wr_ptr, rd_ptr;
  logic res_fire, mis, enq, empty;
  assign empty        = count_o == '0;
  assign pred_ready_o = count_o != (pw+1)'(depth_p);
  assign res_fire     = res_v_i && !empty;
  assign mis          = res_fire && (taken_q[rd_ptr] != res_taken_i);
  assign enq          = pred_v_i && pred_ready_o && !mis;
  // Payload is only read for valid entries, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      idx_q[wr_ptr]    <= pred_idx_i;
      ghist_q[wr_ptr]  <= pred_ghist_i;
      taken_q[wr_ptr]  <= pred_taken_i;
      local_q[wr_ptr]  <= pred_local_i;
      global_q[wr_ptr] <= pred_global_i;
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count_o         <= '0;
      w_v_o           <= 1'b0;
      idx_w_o         <= '0;
      ghist_w_o       <= '0;
      taken_o         <= 1'b0;
      correct_o       <= 1'b0;
      choice_v_o      <= 1'b0;
      choice_global_o <= 1'b0;
      mispredict_o    <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      rd_ptr          <= rd_ptr + pw'(res_fire);
      wr_ptr          <= mis ? rd_ptr + pw'(1) : wr_ptr + pw'(enq);
      count_o         <= mis ? '0 : count_o + (pw+1)'(enq) - (pw+1)'(res_fire);
      w_v_o           <= res_fire;
      choice_v_o      <= res_fire && (local_q[rd_ptr] != global_q[rd_ptr]);
      choice_global_o <= res_fire && (global_q[rd_ptr] == res_taken_i);
      mispredict_o    <= mis;
      err_o           <= err_o || (res_v_i && empty);
      if (res_fire) begin
        idx_w_o   <= idx_q[rd_ptr];
        ghist_w_o <= ghist_q[rd_ptr];
        taken_o   <= res_taken_i;
        correct_o <= !mis;
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed table vectors plus hand sequences for fill, wrap, flush and async reset.
module tb_branch_resolve_queue;
  logic clk = 0, reset_n = 0;
  logic pred_v, pred_ready, pred_taken, pred_local, pred_global, res_v, res_taken;
  logic [9:0] pred_idx, idx_w;
  logic [11:0] pred_ghist, ghist_w;
  logic w_v, taken, correct, choice_v, choice_global, mispredict, err;
  logic [3:0] count;
  int n_cmp = 0, n_bad = 0;

  branch_resolve_queue dut (
    .clk_i(clk), .reset_n_i(reset_n), .pred_v_i(pred_v), .pred_ready_o(pred_ready),
    .pred_idx_i(pred_idx), .pred_ghist_i(pred_ghist), .pred_taken_i(pred_taken),
    .pred_local_i(pred_local), .pred_global_i(pred_global), .res_v_i(res_v),
    .res_taken_i(res_taken), .w_v_o(w_v), .idx_w_o(idx_w), .ghist_w_o(ghist_w),
    .taken_o(taken), .correct_o(correct), .choice_v_o(choice_v),
    .choice_global_o(choice_global), .mispredict_o(mispredict), .count_o(count), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pv; logic [9:0] idx; logic [11:0] gh; logic t, l, g, rv, rt;
    logic ew; logic [9:0] eidx; logic [11:0] egh; logic ec, ecv, ecg, em; int ecnt; logic eerr;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pv, input logic [9:0] idx, input logic [11:0] gh,
                       input logic t, input logic l, input logic g, input logic rv, input logic rt);
    pred_v = pv; pred_idx = idx; pred_ghist = gh; pred_taken = t;
    pred_local = l; pred_global = g; res_v = rv; res_taken = rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 0;
    step();
    step();
    chk("rst_count", count, 0);
    chk("rst_ready", pred_ready, 1);
    chk("rst_wv", w_v, 0);
    chk("rst_err", err, 0);
    chk("rst_mis", mispredict, 0);
    reset_n = 1;
  endtask

  initial begin
    int exp_q [$];
    int e;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0] = '{1, 10'h005, 12'h0AB, 1, 1, 0, 0, 0,  0, 10'h000, 12'h000, 0, 0, 0, 0, 1, 0};
    tbl[1] = '{0, 10'h000, 12'h000, 0, 0, 0, 1, 1,  1, 10'h005, 12'h0AB, 1, 1, 0, 0, 0, 0};
    tbl[2] = '{0, 10'h000, 12'h000, 0, 0, 0, 0, 0,  0, 10'h000, 12'h000, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{1, 10'h012, 12'h123, 0, 0, 1, 0, 0,  0, 10'h000, 12'h000, 0, 0, 0, 0, 1, 0};
    tbl[4] = '{1, 10'h013, 12'h456, 1, 1, 1, 1, 0,  1, 10'h012, 12'h123, 1, 1, 0, 0, 1, 0};
    tbl[5] = '{0, 10'h000, 12'h000, 0, 0, 0, 1, 1,  1, 10'h013, 12'h456, 1, 0, 0, 0, 0, 0};
    tbl[6] = '{1, 10'h020, 12'h0F0, 1, 0, 1, 0, 0,  0, 10'h000, 12'h000, 0, 0, 0, 0, 1, 0};
    tbl[7] = '{1, 10'h021, 12'h0F1, 1, 1, 1, 0, 0,  0, 10'h000, 12'h000, 0, 0, 0, 0, 2, 0};
    tbl[8] = '{1, 10'h022, 12'h0F2, 0, 0, 0, 1, 0,  1, 10'h020, 12'h0F0, 0, 1, 0, 1, 0, 0};
    tbl[9] = '{0, 10'h000, 12'h000, 0, 0, 0, 1, 1,  0, 10'h000, 12'h000, 0, 0, 0, 0, 0, 1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].pv, tbl[i].idx, tbl[i].gh, tbl[i].t, tbl[i].l, tbl[i].g, tbl[i].rv, tbl[i].rt);
      step();
      chk($sformatf("v%0d_wv", i), w_v, tbl[i].ew);
      chk($sformatf("v%0d_count", i), count, tbl[i].ecnt);
      chk($sformatf("v%0d_mis", i), mispredict, tbl[i].em);
      chk($sformatf("v%0d_cv", i), choice_v, tbl[i].ecv);
      chk($sformatf("v%0d_err", i), err, tbl[i].eerr);
      if (tbl[i].ew) begin
        chk($sformatf("v%0d_idx", i), idx_w, tbl[i].eidx);
        chk($sformatf("v%0d_gh", i), ghist_w, tbl[i].egh);
        chk($sformatf("v%0d_corr", i), correct, tbl[i].ec);
        chk($sformatf("v%0d_taken", i), taken, tbl[i].rt);
        if (tbl[i].ecv) chk($sformatf("v%0d_cg", i), choice_global, tbl[i].ecg);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // fill to depth, drop the ninth, drain in order
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 10'(10'h040 + i), 12'(i), i[0], 0, 0, 0, 0);
      step();
      chk("fill_count", count, i + 1);
    end
    chk("full_ready", pred_ready, 0);
    drive(1, 10'h099, 12'hFFF, 0, 0, 0, 0, 0);
    step();
    chk("drop_count", count, 8);
    chk("drop_ready", pred_ready, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, i[0]);
      step();
      chk("drain_wv", w_v, 1);
      chk("drain_idx", idx_w, 10'h040 + i);
      chk("drain_corr", correct, 1);
      chk("drain_count", count, 7 - i);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("drain_idle_wv", w_v, 0);
    chk("drain_ready", pred_ready, 1);

    // steady enqueue+resolve at occupancy 4 across pointer wraps
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1, 10'(10'h100 + k), 0, 1, 0, 0, 0, 0);
      exp_q.push_back(10'h100 + k);
      step();
    end
    chk("wrap_pre_count", count, 4);
    for (int k = 4; k < 24; k++) begin
      drive(1, 10'(10'h100 + k), 0, 1, 0, 0, 1, 1);
      exp_q.push_back(10'h100 + k);
      e = exp_q.pop_front();
      step();
      chk("wrap_count", count, 4);
      chk("wrap_wv", w_v, 1);
      chk("wrap_idx", idx_w, e);
      chk("wrap_mis", mispredict, 0);
    end

    // mispredict flushes, then resolve-on-empty sets sticky err
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 10'(10'h200 + k), 0, 1, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    chk("flush_mis", mispredict, 1);
    chk("flush_count", count, 0);
    chk("flush_idx", idx_w, 10'h200);
    chk("flush_corr", correct, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("flush_mis_pulse", mispredict, 0);
    chk("flush_err_pre", err, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    step();
    chk("empty_res_wv", w_v, 0);
    chk("empty_res_err", err, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("err_sticky", err, 1);

    // asynchronous reset mid-cycle with 5 entries and an update pending
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1, 10'(10'h300 + k), 0, 1, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    step();
    chk("ar_pre_count", count, 5);
    chk("ar_pre_wv", w_v, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset_n = 0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_wv", w_v, 0);
    chk("ar_ready", pred_ready, 1);
    @(negedge clk);
    reset_n = 1;
    step();
    chk("ar_post_wv", w_v, 0);
    chk("ar_post_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
